// File: rtl/rob_pred_if.sv
// Handshake bundle for rob_pred: allocation, two writeback channels, commit and flush.
// master = decoder/RS/LSB side, slave = reorder buffer.
interface rob_pred_if #(
    parameter int ROB_WIDTH = 4
);
    logic                 alloc_valid;
    logic [2:0]           alloc_op;
    logic [4:0]           alloc_rd;
    logic [31:0]          alloc_pred_pc;
    logic [ROB_WIDTH-1:0] alloc_tag;
    logic                 alloc_ready;

    logic                 wb0_valid;
    logic [ROB_WIDTH-1:0] wb0_tag;
    logic [31:0]          wb0_wdata;
    logic [31:0]          wb0_pc;

    logic                 wb1_valid;
    logic [ROB_WIDTH-1:0] wb1_tag;
    logic [31:0]          wb1_wdata;

    logic                 cm_reg;
    logic [4:0]           cm_rd;
    logic [31:0]          cm_wdata;
    logic [ROB_WIDTH-1:0] cm_tag;
    logic                 cm_store;
    logic [ROB_WIDTH-1:0] cm_store_tag;
    logic                 flush;
    logic [31:0]          flush_pc;

    modport master (
        output alloc_valid, alloc_op, alloc_rd, alloc_pred_pc,
        input  alloc_tag, alloc_ready,
        output wb0_valid, wb0_tag, wb0_wdata, wb0_pc,
        output wb1_valid, wb1_tag, wb1_wdata,
        input  cm_reg, cm_rd, cm_wdata, cm_tag, cm_store, cm_store_tag, flush, flush_pc
    );

    modport slave (
        input  alloc_valid, alloc_op, alloc_rd, alloc_pred_pc,
        output alloc_tag, alloc_ready,
        input  wb0_valid, wb0_tag, wb0_wdata, wb0_pc,
        input  wb1_valid, wb1_tag, wb1_wdata,
        output cm_reg, cm_rd, cm_wdata, cm_tag, cm_store, cm_store_tag, flush, flush_pc
    );
endinterface

// File: rtl/rob_pred.sv
// rob_pred: circular reorder buffer, dual writeback, in-order retire with mispredict flush.
// Define ROB_PERF_EN to add the perf_commits/perf_flushes counters.
module rob_pred #(
    parameter int ROB_WIDTH   = 4,
    parameter int FULL_MARGIN = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
`ifdef ROB_PERF_EN
    output logic [31:0] perf_commits,
    output logic [31:0] perf_flushes,
`endif
    rob_pred_if.slave   rob
);
    localparam int DEPTH = 1 << ROB_WIDTH;

    typedef logic [ROB_WIDTH-1:0] tag_t;
    typedef logic [ROB_WIDTH:0]   cnt_t;
    typedef enum logic [2:0] {
        OP_WRITE   = 3'd0,
        OP_JUMP    = 3'd1,
        OP_BOTH    = 3'd2,
        OP_LOAD    = 3'd3,
        OP_STORE   = 3'd4,
        OP_NOTHING = 3'd5
    } op_e;

    localparam tag_t TAG_ONE = tag_t'(1);
    localparam cnt_t CNT_ONE = cnt_t'(1);

    op_e         op_q    [DEPTH];
    logic [4:0]  rd_q    [DEPTH];
    logic [31:0] pred_q  [DEPTH];
    logic [31:0] wdata_q [DEPTH];
    logic [31:0] pc_q    [DEPTH];

    logic [DEPTH-1:0] ready_q, ready_d, busy_q, busy_d;
    tag_t  head_q, head_d, tail_q, tail_d;
    cnt_t  count_q, count_d;
    logic  alloc_ready_q, alloc_ready_d;
    logic  cm_reg_q, cm_reg_d, cm_store_q, cm_store_d, flush_q, flush_d;
    logic [4:0]  cm_rd_q, cm_rd_d;
    logic [31:0] cm_wdata_q, cm_wdata_d, flush_pc_q, flush_pc_d;
    tag_t  cm_tag_q, cm_tag_d, cm_store_tag_q, cm_store_tag_d;

    op_e  head_op, wb0_op, wb1_op;
    logic do_alloc, do_commit, mispred, wb0_en, wb1_en, wb1_ld;

    assign head_op   = op_q[head_q];
    assign wb0_op    = op_q[rob.wb0_tag];
    assign wb1_op    = op_q[rob.wb1_tag];
    // While flush is high every input is dropped; the buffer empties on that edge.
    assign do_alloc  = rob.alloc_valid && alloc_ready_q && !flush_q;
    assign do_commit = !flush_q && (count_q != '0) && ready_q[head_q];
    assign mispred   = (head_op == OP_JUMP || head_op == OP_BOTH) && (pc_q[head_q] != pred_q[head_q]);
    assign wb0_en    = rob.wb0_valid && !flush_q && busy_q[rob.wb0_tag]
                       && wb0_op != OP_LOAD && wb0_op != OP_STORE;
    assign wb1_en    = rob.wb1_valid && !flush_q && busy_q[rob.wb1_tag]
                       && (wb1_op == OP_LOAD || wb1_op == OP_STORE);
    assign wb1_ld    = wb1_en && wb1_op == OP_LOAD;

    always_comb begin
        ready_d        = ready_q;
        busy_d         = busy_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        cm_reg_d       = 1'b0;
        cm_store_d     = 1'b0;
        flush_d        = 1'b0;
        cm_rd_d        = cm_rd_q;
        cm_wdata_d     = cm_wdata_q;
        cm_tag_d       = cm_tag_q;
        cm_store_tag_d = cm_store_tag_q;
        flush_pc_d     = flush_pc_q;

        if (flush_q) begin
            ready_d = '0;
            busy_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wb0_en) ready_d[rob.wb0_tag] = 1'b1;
            if (wb1_en) ready_d[rob.wb1_tag] = 1'b1;

            if (do_commit) begin
                ready_d[head_q] = 1'b0;
                busy_d[head_q]  = 1'b0;
                head_d          = head_q + TAG_ONE;
                cm_tag_d        = head_q;
                case (head_op)
                    OP_WRITE, OP_LOAD, OP_BOTH: begin
                        cm_reg_d   = 1'b1;
                        cm_rd_d    = rd_q[head_q];
                        cm_wdata_d = wdata_q[head_q];
                    end
                    OP_STORE: begin
                        cm_store_d     = 1'b1;
                        cm_store_tag_d = head_q;
                    end
                    default: ;
                endcase
                if (mispred) begin
                    flush_d    = 1'b1;
                    flush_pc_d = pc_q[head_q];
                end
            end

            if (do_alloc) begin
                busy_d[tail_q]  = 1'b1;
                ready_d[tail_q] = (op_e'(rob.alloc_op) == OP_NOTHING);
                tail_d          = tail_q + TAG_ONE;
            end

            case ({do_alloc, do_commit})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: ;
            endcase
        end

        alloc_ready_d = (32'(count_d) + 32'(FULL_MARGIN)) < 32'(DEPTH);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in) begin
            if (do_alloc) begin
                op_q[tail_q]   <= op_e'(rob.alloc_op);
                rd_q[tail_q]   <= rob.alloc_rd;
                pred_q[tail_q] <= rob.alloc_pred_pc;
            end
            if (wb0_en) begin
                wdata_q[rob.wb0_tag] <= rob.wb0_wdata;
                pc_q[rob.wb0_tag]    <= rob.wb0_pc;
            end
            if (wb1_ld) wdata_q[rob.wb1_tag] <= rob.wb1_wdata;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ready_q        <= '0;
            busy_q         <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            alloc_ready_q  <= 1'b1;
            cm_reg_q       <= 1'b0;
            cm_store_q     <= 1'b0;
            flush_q        <= 1'b0;
            cm_rd_q        <= '0;
            cm_wdata_q     <= '0;
            cm_tag_q       <= '0;
            cm_store_tag_q <= '0;
            flush_pc_q     <= '0;
        end else if (rdy_in) begin
            ready_q        <= ready_d;
            busy_q         <= busy_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            alloc_ready_q  <= alloc_ready_d;
            cm_reg_q       <= cm_reg_d;
            cm_store_q     <= cm_store_d;
            flush_q        <= flush_d;
            cm_rd_q        <= cm_rd_d;
            cm_wdata_q     <= cm_wdata_d;
            cm_tag_q       <= cm_tag_d;
            cm_store_tag_q <= cm_store_tag_d;
            flush_pc_q     <= flush_pc_d;
        end
    end

    assign rob.alloc_tag    = tail_q;
    assign rob.alloc_ready  = alloc_ready_q;
    assign rob.cm_reg       = cm_reg_q;
    assign rob.cm_rd        = cm_rd_q;
    assign rob.cm_wdata     = cm_wdata_q;
    assign rob.cm_tag       = cm_tag_q;
    assign rob.cm_store     = cm_store_q;
    assign rob.cm_store_tag = cm_store_tag_q;
    assign rob.flush        = flush_q;
    assign rob.flush_pc     = flush_pc_q;

`ifdef ROB_PERF_EN
    logic [31:0] perf_commits_q, perf_flushes_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            perf_commits_q <= '0;
            perf_flushes_q <= '0;
        end else if (rdy_in) begin
            if (do_commit) perf_commits_q <= perf_commits_q + 32'd1;
            if (flush_d)   perf_flushes_q <= perf_flushes_q + 32'd1;
        end
    end

    assign perf_commits = perf_commits_q;
    assign perf_flushes = perf_flushes_q;
`endif
endmodule

// File: tb/tb_rob_pred.sv
// Directed self-checking bench for rob_pred (ROB_WIDTH=4, FULL_MARGIN=4).
// Perf-counter scenario runs only when ROB_PERF_EN is defined.
module tb_rob_pred;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rob_pred_if #(.ROB_WIDTH(W)) rif ();

`ifdef ROB_PERF_EN
    logic [31:0] perf_commits, perf_flushes;
`endif

    rob_pred #(.ROB_WIDTH(W), .FULL_MARGIN(4)) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .rdy_in       (rdy),
`ifdef ROB_PERF_EN
        .perf_commits (perf_commits),
        .perf_flushes (perf_flushes),
`endif
        .rob          (rif)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in;
        rif.alloc_valid = 1'b0; rif.alloc_op = 3'd0; rif.alloc_rd = 5'd0; rif.alloc_pred_pc = 32'd0;
        rif.wb0_valid = 1'b0; rif.wb0_tag = '0; rif.wb0_wdata = 32'd0; rif.wb0_pc = 32'd0;
        rif.wb1_valid = 1'b0; rif.wb1_tag = '0; rif.wb1_wdata = 32'd0;
    endtask

    task automatic set_alloc(input logic [2:0] op, input logic [4:0] rd, input logic [31:0] pc);
        rif.alloc_valid = 1'b1; rif.alloc_op = op; rif.alloc_rd = rd; rif.alloc_pred_pc = pc;
    endtask

    task automatic set_wb0(input logic [W-1:0] tag, input logic [31:0] data, input logic [31:0] pc);
        rif.wb0_valid = 1'b1; rif.wb0_tag = tag; rif.wb0_wdata = data; rif.wb0_pc = pc;
    endtask

    task automatic set_wb1(input logic [W-1:0] tag, input logic [31:0] data);
        rif.wb1_valid = 1'b1; rif.wb1_tag = tag; rif.wb1_wdata = data;
    endtask

    task automatic do_reset;
        clr_in();
        rdy = 1'b1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({rif.cm_reg, rif.cm_store, rif.flush} !== 3'b000) begin
            errors++; $display("FAIL reset_strobes got %b want 000", {rif.cm_reg, rif.cm_store, rif.flush});
        end
        checks++;
        if ({rif.cm_rd, rif.cm_wdata, rif.cm_tag, rif.cm_store_tag, rif.flush_pc} !== '0) begin
            errors++; $display("FAIL reset_data got rd=%0h wd=%0h tag=%0h stag=%0h fpc=%0h want all 0",
                               rif.cm_rd, rif.cm_wdata, rif.cm_tag, rif.cm_store_tag, rif.flush_pc);
        end
        checks++;
        if (rif.alloc_tag !== 4'd0 || rif.alloc_ready !== 1'b1) begin
            errors++; $display("FAIL reset_alloc got tag=%0h rdy=%b want tag=0 rdy=1", rif.alloc_tag, rif.alloc_ready);
        end
    endtask

    task automatic test_write;
        do_reset();
        set_alloc(3'd0, 5'd5, 32'd0); tick();
        clr_in();
        checks++;
        if (rif.alloc_tag !== 4'd1) begin
            errors++; $display("FAIL write_alloc_tag got %0h want 1", rif.alloc_tag);
        end
        set_wb0(4'd0, 32'h1234, 32'd0); tick();
        clr_in();
        checks++;
        if (rif.cm_reg !== 1'b0) begin
            errors++; $display("FAIL write_same_edge got cm_reg=%b want 0", rif.cm_reg);
        end
        tick();
        checks++;
        if ({rif.cm_reg, rif.cm_rd, rif.cm_wdata, rif.cm_tag} !== {1'b1, 5'd5, 32'h1234, 4'd0}) begin
            errors++; $display("FAIL write_commit got reg=%b rd=%0d wd=%0h tag=%0h want reg=1 rd=5 wd=1234 tag=0",
                               rif.cm_reg, rif.cm_rd, rif.cm_wdata, rif.cm_tag);
        end
        tick();
        checks++;
        if (rif.cm_reg !== 1'b0) begin
            errors++; $display("FAIL write_pulse got cm_reg=%b want 0", rif.cm_reg);
        end
    endtask

    task automatic test_jump;
        do_reset();
        set_alloc(3'd1, 5'd0, 32'h100); tick();
        set_alloc(3'd1, 5'd0, 32'h104); set_wb0(4'd0, 32'd0, 32'h100); tick();
        set_alloc(3'd0, 5'd7, 32'd0);   set_wb0(4'd1, 32'd0, 32'h200); tick();
        checks++;
        if ({rif.flush, rif.cm_reg, rif.cm_tag} !== {1'b0, 1'b0, 4'd0}) begin
            errors++; $display("FAIL jump_hit got flush=%b reg=%b tag=%0h want 0 0 0", rif.flush, rif.cm_reg, rif.cm_tag);
        end
        rif.alloc_valid = 1'b0; set_wb0(4'd2, 32'h55, 32'd0); tick();
        checks++;
        if ({rif.flush, rif.flush_pc, rif.cm_tag} !== {1'b1, 32'h200, 4'd1}) begin
            errors++; $display("FAIL jump_miss got flush=%b pc=%0h tag=%0h want 1 200 1", rif.flush, rif.flush_pc, rif.cm_tag);
        end
        clr_in(); set_alloc(3'd0, 5'd8, 32'd0); tick();
        clr_in();
        checks++;
        if ({rif.flush, rif.alloc_tag, rif.alloc_ready} !== {1'b0, 4'd0, 1'b1}) begin
            errors++; $display("FAIL jump_after_flush got flush=%b atag=%0h ardy=%b want 0 0 1",
                               rif.flush, rif.alloc_tag, rif.alloc_ready);
        end
        tick(); tick();
        checks++;
        if ({rif.cm_reg, rif.cm_tag, rif.alloc_tag} !== {1'b0, 4'd1, 4'd0}) begin
            errors++; $display("FAIL jump_younger got reg=%b tag=%0h atag=%0h want 0 1 0", rif.cm_reg, rif.cm_tag, rif.alloc_tag);
        end
    endtask

    task automatic test_load_store;
        do_reset();
        set_alloc(3'd5, 5'd0, 32'd0); tick();
        set_alloc(3'd3, 5'd9, 32'd0); tick();
        checks++;
        if ({rif.cm_reg, rif.cm_store, rif.alloc_tag, rif.alloc_ready} !== {1'b0, 1'b0, 4'd2, 1'b1}) begin
            errors++; $display("FAIL ls_nothing got reg=%b st=%b atag=%0h ardy=%b want 0 0 2 1",
                               rif.cm_reg, rif.cm_store, rif.alloc_tag, rif.alloc_ready);
        end
        set_alloc(3'd4, 5'd0, 32'd0); tick();
        clr_in(); set_wb1(4'd2, 32'hffff); tick();
        set_wb1(4'd1, 32'hdead); tick();
        checks++;
        if ({rif.cm_reg, rif.cm_store} !== 2'b00) begin
            errors++; $display("FAIL ls_order got reg=%b st=%b want 0 0", rif.cm_reg, rif.cm_store);
        end
        clr_in(); tick();
        checks++;
        if ({rif.cm_reg, rif.cm_store, rif.cm_rd, rif.cm_wdata, rif.cm_tag} !== {1'b1, 1'b0, 5'd9, 32'hdead, 4'd1}) begin
            errors++; $display("FAIL ls_load got reg=%b st=%b rd=%0d wd=%0h tag=%0h want 1 0 9 dead 1",
                               rif.cm_reg, rif.cm_store, rif.cm_rd, rif.cm_wdata, rif.cm_tag);
        end
        tick();
        checks++;
        if ({rif.cm_reg, rif.cm_store, rif.cm_store_tag, rif.cm_tag, rif.cm_wdata} !== {1'b0, 1'b1, 4'd2, 4'd2, 32'hdead}) begin
            errors++; $display("FAIL ls_store got reg=%b st=%b stag=%0h tag=%0h wd=%0h want 0 1 2 2 dead",
                               rif.cm_reg, rif.cm_store, rif.cm_store_tag, rif.cm_tag, rif.cm_wdata);
        end
    endtask

    task automatic test_full_wrap;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            set_alloc(3'd0, 5'(i), 32'd0); tick();
        end
        checks++;
        if (rif.alloc_ready !== 1'b1) begin
            errors++; $display("FAIL full_11 got ardy=%b want 1", rif.alloc_ready);
        end
        set_alloc(3'd0, 5'd11, 32'd0); tick();
        checks++;
        if ({rif.alloc_ready, rif.alloc_tag} !== {1'b0, 4'd12}) begin
            errors++; $display("FAIL full_12 got ardy=%b atag=%0h want 0 c", rif.alloc_ready, rif.alloc_tag);
        end
        set_alloc(3'd0, 5'd12, 32'd0); tick();
        checks++;
        if (rif.alloc_tag !== 4'd12) begin
            errors++; $display("FAIL full_blocked got atag=%0h want c", rif.alloc_tag);
        end
        clr_in(); set_wb0(4'd0, 32'ha0, 32'd0); tick();
        clr_in(); tick();
        checks++;
        if ({rif.alloc_ready, rif.cm_reg, rif.cm_tag, rif.cm_wdata} !== {1'b1, 1'b1, 4'd0, 32'ha0}) begin
            errors++; $display("FAIL full_release got ardy=%b reg=%b tag=%0h wd=%0h want 1 1 0 a0",
                               rif.alloc_ready, rif.cm_reg, rif.cm_tag, rif.cm_wdata);
        end
        for (int k = 1; k <= 11; k++) begin
            set_wb0(4'(k), 32'h100 + 32'(k), 32'd0); tick();
            if (k > 1) begin
                checks++;
                if ({rif.cm_tag, rif.cm_wdata} !== {4'(k - 1), 32'h100 + 32'(k - 1)}) begin
                    errors++; $display("FAIL drain_%0d got tag=%0h wd=%0h want %0h %0h",
                                       k, rif.cm_tag, rif.cm_wdata, k - 1, 32'h100 + k - 1);
                end
            end
        end
        clr_in(); tick();
        checks++;
        if ({rif.cm_tag, rif.alloc_tag, rif.alloc_ready} !== {4'd11, 4'd12, 1'b1}) begin
            errors++; $display("FAIL drain_last got tag=%0h atag=%0h ardy=%b want b c 1", rif.cm_tag, rif.alloc_tag, rif.alloc_ready);
        end
        for (int i = 0; i < 4; i++) begin
            set_alloc(3'd0, 5'(20 + i), 32'd0); tick();
        end
        checks++;
        if (rif.alloc_tag !== 4'd0) begin
            errors++; $display("FAIL wrap_tail got atag=%0h want 0", rif.alloc_tag);
        end
        set_alloc(3'd0, 5'd24, 32'd0); tick();
        clr_in();
        checks++;
        if (rif.alloc_tag !== 4'd1) begin
            errors++; $display("FAIL wrap_tail1 got atag=%0h want 1", rif.alloc_tag);
        end
        for (int i = 0; i < 5; i++) begin
            set_wb0(4'(12 + i), 32'h200 + 32'(i), 32'd0); tick();
            if (i > 0) begin
                checks++;
                if ({rif.cm_reg, rif.cm_tag, rif.cm_rd} !== {1'b1, 4'(11 + i), 5'(19 + i)}) begin
                    errors++; $display("FAIL wrap_commit_%0d got reg=%b tag=%0h rd=%0d want 1 %0h %0d",
                                       i, rif.cm_reg, rif.cm_tag, rif.cm_rd, (11 + i) % 16, 19 + i);
                end
            end
        end
        clr_in(); tick();
        checks++;
        if ({rif.cm_reg, rif.cm_tag, rif.cm_rd, rif.cm_wdata} !== {1'b1, 4'd0, 5'd24, 32'h204}) begin
            errors++; $display("FAIL wrap_last got reg=%b tag=%0h rd=%0d wd=%0h want 1 0 24 204",
                               rif.cm_reg, rif.cm_tag, rif.cm_rd, rif.cm_wdata);
        end
    endtask

    task automatic test_dual_wb_stall;
        do_reset();
        set_alloc(3'd3, 5'd3, 32'd0); tick();
        set_alloc(3'd0, 5'd4, 32'd0); set_wb0(4'd0, 32'h1, 32'd0); set_wb1(4'd0, 32'h2); tick();
        clr_in(); set_wb0(4'd1, 32'h77, 32'd0); tick();
        checks++;
        if ({rif.cm_reg, rif.cm_rd, rif.cm_wdata, rif.cm_tag} !== {1'b1, 5'd3, 32'h2, 4'd0}) begin
            errors++; $display("FAIL dual_wb got reg=%b rd=%0d wd=%0h tag=%0h want 1 3 2 0",
                               rif.cm_reg, rif.cm_rd, rif.cm_wdata, rif.cm_tag);
        end
        clr_in(); rdy = 1'b0; set_alloc(3'd0, 5'd5, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({rif.cm_reg, rif.cm_tag, rif.cm_wdata, rif.alloc_tag} !== {1'b1, 4'd0, 32'h2, 4'd2}) begin
                errors++; $display("FAIL stall_%0d got reg=%b tag=%0h wd=%0h atag=%0h want 1 0 2 2",
                                   i, rif.cm_reg, rif.cm_tag, rif.cm_wdata, rif.alloc_tag);
            end
        end
        rdy = 1'b1; clr_in(); tick();
        checks++;
        if ({rif.cm_reg, rif.cm_rd, rif.cm_wdata, rif.cm_tag, rif.alloc_tag} !== {1'b1, 5'd4, 32'h77, 4'd1, 4'd2}) begin
            errors++; $display("FAIL stall_resume got reg=%b rd=%0d wd=%0h tag=%0h atag=%0h want 1 4 77 1 2",
                               rif.cm_reg, rif.cm_rd, rif.cm_wdata, rif.cm_tag, rif.alloc_tag);
        end
    endtask

`ifdef ROB_PERF_EN
    task automatic test_perf;
        do_reset();
        set_alloc(3'd0, 5'd1, 32'd0); tick();
        set_alloc(3'd1, 5'd0, 32'h10); set_wb0(4'd0, 32'h5, 32'd0); tick();
        set_alloc(3'd1, 5'd0, 32'h20); set_wb0(4'd1, 32'd0, 32'h10); tick();
        clr_in(); set_wb0(4'd2, 32'd0, 32'h24); tick();
        clr_in(); tick();
        tick(); tick();
        checks++;
        if ({perf_commits, perf_flushes} !== {32'd3, 32'd1}) begin
            errors++; $display("FAIL perf got commits=%0d flushes=%0d want 3 1", perf_commits, perf_flushes);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_jump();
        test_load_store();
        test_full_wrap();
        test_dual_wb_stall();
`ifdef ROB_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rob_pred.md
# rob_pred

Parametrised reorder buffer for the out-of-order RISC-V core, the successor to the single-writeback ROB. It sits between decoder/RS/LSB and the register file and IF:
- allocates tags in program order and records op, rd and predicted next PC at issue;
- accepts results from two writeback channels, ALU/RS and LSB;
- retires in order, flushing the pipeline only when a control-transfer result disagrees with its prediction.

## Interface
Parameters:
- ROB_WIDTH, 4, tag width; depth = 2^ROB_WIDTH.
- FULL_MARGIN, 4, number of free slots kept in reserve for in-flight decodes; alloc_ready drops when count + FULL_MARGIN >= depth.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous, active-high reset.
- rdy_in  in  1  global enable; when low, all state and outputs hold.
- alloc_valid  in  1  decoder allocates one entry.
- alloc_op  in  3  op: WRITE=0, JUMP=1, BOTH=2, LOAD=3, STORE=4, NOTHING=5.
- alloc_rd  in  5  destination register.
- alloc_pred_pc  in  32  predicted next PC (used by JUMP/BOTH).
- alloc_tag  out  ROB_WIDTH  tag the next allocation receives (= tail).
- alloc_ready  out  1  space available for allocation.
- wb0_valid  in  1  RS/ALU result.
- wb0_tag  in  ROB_WIDTH  tag of the RS/ALU result.
- wb0_wdata  in  32  result data.
- wb0_pc  in  32  resolved next PC.
- wb1_valid  in  1  LSB result.
- wb1_tag  in  ROB_WIDTH  tag of the LSB result.
- wb1_wdata  in  32  load data; ignored for STORE.
- cm_reg  out  1  register-file write strobe.
- cm_rd  out  5  register-file write address.
- cm_wdata  out  32  register-file write data.
- cm_tag  out  ROB_WIDTH  tag of the retiring entry.
- cm_store  out  1  release store to LSB.
- cm_store_tag  out  ROB_WIDTH  tag of the released store.
- flush  out  1  misprediction flush pulse.
- flush_pc  out  32  PC to redirect IF to.

## Operation
- Circular buffer: head and tail are ROB_WIDTH bits wide and wrap naturally. Occupancy count is ROB_WIDTH+1 bits; empty when count==0, so head==tail is never used as the full/empty test.
- Allocation: accepted when alloc_valid && alloc_ready && !flush. Writes op/rd/pred_pc, clears ready except for NOTHING, which is ready at allocation, then advances tail.
- Writeback:
  - wb0 sets ready for all ops except LOAD and STORE, and stores wdata and the resolved PC.
  - wb1 sets ready and stores wdata for LOAD, and sets ready for STORE.
  - If both channels target the same tag in one cycle, wb1 wins.
  - Writebacks to a non-busy slot are ignored.
- Commit, at most one per cycle, when count>0 and ready[head]:
  - WRITE/LOAD: cm_reg=1 with rd and wdata.
  - STORE: cm_store=1 with cm_store_tag=head.
  - JUMP: flush only if the resolved PC != pred_pc.
  - BOTH: cm_reg=1, plus flush if the resolved PC != pred_pc.
  - NOTHING: retires silently.
  - cm_tag=head for every commit; head advances.
- Flush: in the cycle after flush is high, head=tail=count=0, all ready bits clear, and alloc/writeback inputs in that cycle are discarded. flush_pc holds the resolved PC.

## Timing
- All outputs are registered; commit strobes, flush, cm_store and cm_reg are one-cycle pulses.
- Reset values: cm_reg=0, cm_store=0, flush=0, cm_rd=0, cm_wdata=0, cm_tag=0, cm_store_tag=0, flush_pc=0, alloc_tag=0, alloc_ready=1, head=tail=count=0.
- Writeback-to-commit latency: a result written at edge N is committed at edge N+1 (strobe visible after N+1). Same-edge writeback and commit of the head entry is not allowed; the commit sees the old ready bit.
- alloc_ready is computed from the post-update count: count' = count + alloc − commit. It deasserts the edge after count' + FULL_MARGIN >= 2^ROB_WIDTH.
- Simultaneous alloc and commit: count is unchanged and both pointers advance.
- Reset mid-operation overrides flush, commit and alloc in the same cycle.

## Configuration
- ROB_PERF_EN defined:
  - adds outputs perf_commits (32) and perf_flushes (32), free-running wrapping counters reset to 0;
  - incremented on each commit and each flush pulse;
  - preserved across flush, cleared only by rst_in.
- ROB_PERF_EN undefined: ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset, then allocate WRITE rd=5 (tag 0); wb0 tag0 wdata=0x1234 → next edge cm_reg=1, cm_rd=5, cm_wdata=0x1234, cm_tag=0.
- JUMP with pred_pc=0x100 and wb0_pc=0x100 → commits with flush=0. Repeat with wb0_pc=0x200 → flush=1, flush_pc=0x200; next cycle alloc_tag=0 and younger entries never commit.
- Allocate LOAD tag1 and STORE tag2; send wb1 for tag2 first, then tag1 with 0xdead → cm_reg for tag1 with 0xdead, then cm_store=1 with cm_store_tag=2, in order.
- ROB_WIDTH=4, FULL_MARGIN=4: allocate 12 entries without commit → alloc_ready=0; commit one → alloc_ready=1; allocation wraps tail 15→0 correctly.
- Same-cycle wb0 and wb1 to one LOAD tag (0x1 vs 0x2) → committed value 0x2. With rdy_in low for 3 cycles mid-stream → no commits, state held.
- ROB_PERF_EN: 3 commits including 1 mispredict → perf_commits=3, perf_flushes=1; both survive the flush.
